// File: rtl/motion_pkg.sv
// Shared widths and FSM state encoding for the three-zone PIR motion alarm.
package motion_pkg;

  localparam int NUM_SENSORS = 3;
  localparam int SENSOR_W    = 7;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    ALARM    = 2'd3
  } state_t;

endpackage

// File: rtl/pir_debounce.sv
// Per-zone hit debouncer: counts consecutive hit scans, saturating at HIT_COUNT.
// fire marks the scan that completes the run, so the FSM can register it on the same edge.
module pir_debounce #(
  parameter int HIT_COUNT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample_en,
  input  logic hit,
  output logic fire
);

  localparam int CNT_W = $clog2(HIT_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HIT_COUNT);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(HIT_COUNT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturated counters never re-fire, so a held reading triggers once.
  assign fire = sample_en & hit & ~clear & (r_cnt == CNT_FIRE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (sample_en) begin
      if (!hit) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/motion_alarm_controller.sv
// Three-zone PIR alarm sequencer: round-robin scan, threshold compare, per-zone
// debounce and the DISARMED/ARMING/ARMED/ALARM state machine. All outputs registered.
module motion_alarm_controller
  import motion_pkg::*;
#(
  parameter int THRESHOLD = 20,
  parameter int HIT_COUNT = 2,
  parameter int ARM_DELAY = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                turn,
  input  logic                stop_alarm,
  input  logic [SENSOR_W-1:0] pir_sensor_1,
  input  logic [SENSOR_W-1:0] pir_sensor_2,
  input  logic [SENSOR_W-1:0] pir_sensor_3,
  output logic                alarm,
  output logic                armed,
  output logic [2:0]          zone,
  output logic [1:0]          state
);

  localparam int ARM_W = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
  localparam logic [ARM_W-1:0]    ARM_LAST = ARM_W'(ARM_DELAY - 1);
  localparam logic [SENSOR_W-1:0] THR      = SENSOR_W'(THRESHOLD);

  state_t                r_state, w_state_nxt;
  logic [ARM_W-1:0]      r_arm_cnt, w_arm_nxt;
  logic [1:0]            r_scan_idx;
  logic [2:0]            r_zone, w_zone_nxt;
  logic                  r_alarm, w_alarm_nxt;
  logic                  r_armed;
  logic                  w_clear;
  logic [SENSOR_W-1:0]   w_sensor [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] w_hit;
  logic [NUM_SENSORS-1:0] w_fire;

  assign w_sensor[0] = pir_sensor_1;
  assign w_sensor[1] = pir_sensor_2;
  assign w_sensor[2] = pir_sensor_3;

  // Counters only run while armed; any disarm or acknowledge wipes them.
  assign w_clear = (r_state == DISARMED) || (r_state == ARMING) || !turn ||
                   ((r_state == ALARM) && stop_alarm);

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_zone
    assign w_hit[g] = (w_sensor[g] >= THR);

    pir_debounce #(
      .HIT_COUNT (HIT_COUNT)
    ) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (w_clear),
      .sample_en (r_scan_idx == 2'(g)),
      .hit       (w_hit[g]),
      .fire      (w_fire[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_idx <= 2'd0;
    end else if (r_scan_idx == 2'd2) begin
      r_scan_idx <= 2'd0;
    end else begin
      r_scan_idx <= r_scan_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= DISARMED;
      r_arm_cnt <= '0;
      r_zone    <= 3'b000;
      r_alarm   <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arm_cnt <= w_arm_nxt;
      r_zone    <= w_zone_nxt;
      r_alarm   <= w_alarm_nxt;
      r_armed   <= (w_state_nxt == ARMED) || (w_state_nxt == ALARM);
    end
  end

  // Priority: disarm, then acknowledge, then fire.
  always_comb begin
    w_state_nxt = r_state;
    w_arm_nxt   = r_arm_cnt;
    w_zone_nxt  = r_zone;
    w_alarm_nxt = r_alarm;
    if (!turn) begin
      w_state_nxt = DISARMED;
      w_arm_nxt   = '0;
      w_zone_nxt  = 3'b000;
      w_alarm_nxt = 1'b0;
    end else begin
      case (r_state)
        DISARMED: begin
          w_state_nxt = ARMING;
          w_arm_nxt   = '0;
        end
        ARMING: begin
          if (r_arm_cnt == ARM_LAST) begin
            w_state_nxt = ARMED;
          end else begin
            w_arm_nxt = r_arm_cnt + ARM_W'(1);
          end
        end
        ARMED: begin
          if (|w_fire) begin
            w_state_nxt = ALARM;
            w_alarm_nxt = 1'b1;
            w_zone_nxt  = w_fire;
          end
        end
        ALARM: begin
          if (stop_alarm) begin
            w_state_nxt = ARMING;
            w_arm_nxt   = '0;
            w_zone_nxt  = 3'b000;
            w_alarm_nxt = 1'b0;
          end else begin
            w_zone_nxt = r_zone | w_fire;
          end
        end
      endcase
    end
  end

  assign state = r_state;
  assign alarm = r_alarm;
  assign armed = r_armed;
  assign zone  = r_zone;

endmodule

// File: tb/tb_motion_alarm_controller.sv
// Scoreboarded bench for motion_alarm_controller: a cycle model pushes the expected
// {state, alarm, armed, zone} per edge, each test pops and compares after the edge.
module tb_motion_alarm_controller;

  localparam int THR = 20;
  localparam int HC  = 2;
  localparam int AD  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       turn = 1'b0;
  logic       stop_alarm = 1'b0;
  logic [6:0] pir_sensor_1 = 7'd0;
  logic [6:0] pir_sensor_2 = 7'd0;
  logic [6:0] pir_sensor_3 = 7'd0;
  logic       alarm;
  logic       armed;
  logic [2:0] zone;
  logic [1:0] state;

  int n_total = 0;
  int n_pass  = 0;

  int         m_state = 0;
  int         m_arm   = 0;
  int         m_scan  = 0;
  int         m_cnt [3] = '{0, 0, 0};
  logic [2:0] m_zone  = 3'b000;
  logic       m_alarm = 1'b0;
  logic [6:0] sb [$];
  logic [6:0] exp_v;

  motion_alarm_controller #(
    .THRESHOLD (THR),
    .HIT_COUNT (HC),
    .ARM_DELAY (AD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .turn         (turn),
    .stop_alarm   (stop_alarm),
    .pir_sensor_1 (pir_sensor_1),
    .pir_sensor_2 (pir_sensor_2),
    .pir_sensor_3 (pir_sensor_3),
    .alarm        (alarm),
    .armed        (armed),
    .zone         (zone),
    .state        (state)
  );

  always #10 clk = ~clk;

  function automatic logic [6:0] obs();
    return {state, alarm, armed, zone};
  endfunction

  // Predicts the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    int         rd [3];
    logic [2:0] f;
    bit         clr;
    bit         hit;
    rd = '{int'(pir_sensor_1), int'(pir_sensor_2), int'(pir_sensor_3)};
    f  = 3'b000;
    if (!rst_n) begin
      m_state = 0; m_arm = 0; m_scan = 0; m_cnt = '{0, 0, 0};
      m_zone = 3'b000; m_alarm = 1'b0;
    end else begin
      clr = (m_state < 2) || !turn || (m_state == 3 && stop_alarm);
      hit = rd[m_scan] >= THR;
      if (clr) m_cnt = '{0, 0, 0};
      else if (!hit) m_cnt[m_scan] = 0;
      else begin
        if (m_cnt[m_scan] == HC - 1) f[m_scan] = 1'b1;
        if (m_cnt[m_scan] < HC) m_cnt[m_scan] = m_cnt[m_scan] + 1;
      end
      if (!turn) begin
        m_state = 0; m_zone = 3'b000; m_alarm = 1'b0;
      end else if (m_state == 0) begin
        m_state = 1; m_arm = 0;
      end else if (m_state == 1) begin
        if (m_arm == AD - 1) m_state = 2; else m_arm = m_arm + 1;
      end else if (m_state == 2) begin
        if (f != 3'b000) begin m_state = 3; m_alarm = 1'b1; m_zone = f; end
      end else begin
        if (stop_alarm) begin m_state = 1; m_arm = 0; m_zone = 3'b000; m_alarm = 1'b0; end
        else m_zone = m_zone | f;
      end
      m_scan = (m_scan + 1) % 3;
    end
    sb.push_back({2'(m_state), m_alarm, (m_state >= 2), m_zone});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; turn = 1'b1; stop_alarm = 1'b0;
    pir_sensor_1 = 7'd0; pir_sensor_2 = 7'd0; pir_sensor_3 = 7'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = sb.pop_front(); n_total++;
      if (obs() !== exp_v) $display("FAIL reset_sb cyc=%0d got=%b exp=%b", i, obs(), exp_v);
      else n_pass++;
      n_total++;
      if (obs() !== 7'b0) $display("FAIL reset_outputs cyc=%0d got=%b exp=0000000", i, obs());
      else n_pass++;
    end
  endtask

  task automatic test_arm();
    rst_n = 1'b1; turn = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      exp_v = sb.pop_front(); n_total++;
      if (obs() !== exp_v) $display("FAIL arm_sb edge=%0d got=%b exp=%b", e, obs(), exp_v);
      else n_pass++;
      if (e == 1) begin
        n_total++;
        if (state !== 2'd1) $display("FAIL arm_enter state=%0d exp=1", state);
        else n_pass++;
      end
      if (e == 5) begin
        n_total++;
        if (state !== 2'd2 || armed !== 1'b1 || alarm !== 1'b0)
          $display("FAIL arm_done state=%0d armed=%b alarm=%b exp=2/1/0", state, armed, alarm);
        else n_pass++;
      end
    end
  endtask

  task automatic test_detect();
    int first = 0;
    bit z1 = 0;
    pir_sensor_1 = 7'd29; pir_sensor_3 = 7'd56;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_v = sb.pop_front(); n_total++;
      if (obs() !== exp_v) $display("FAIL detect_sb cyc=%0d got=%b exp=%b", c, obs(), exp_v);
      else n_pass++;
      if (alarm === 1'b1 && first == 0) first = c;
      if (zone[1] === 1'b1) z1 = 1;
    end
    pir_sensor_1 = 7'd0; pir_sensor_3 = 7'd0;
    n_total++;
    if (first < 1 || first > 3 * HC) $display("FAIL detect_latency got=%0d exp=1..%0d", first, 3 * HC);
    else n_pass++;
    n_total++;
    if (zone !== 3'b101 || z1) $display("FAIL detect_zone got=%b bit1_seen=%0d exp=101/0", zone, z1);
    else n_pass++;
  endtask

  task automatic test_stop();
    stop_alarm = 1'b1;
    tick();
    stop_alarm = 1'b0;
    exp_v = sb.pop_front(); n_total++;
    if (obs() !== exp_v) $display("FAIL stop_sb got=%b exp=%b", obs(), exp_v);
    else n_pass++;
    n_total++;
    if (alarm !== 1'b0 || zone !== 3'b000 || state !== 2'd1)
      $display("FAIL stop_ack alarm=%b zone=%b state=%0d exp=0/000/1", alarm, zone, state);
    else n_pass++;
    for (int c = 1; c <= 4; c++) begin
      tick();
      exp_v = sb.pop_front(); n_total++;
      if (obs() !== exp_v) $display("FAIL stop_rearm_sb cyc=%0d got=%b exp=%b", c, obs(), exp_v);
      else n_pass++;
    end
    n_total++;
    if (state !== 2'd2) $display("FAIL stop_rearm state=%0d exp=2", state);
    else n_pass++;
  endtask

  task automatic test_noise();
    bit bad = 0;
    pir_sensor_2 = 7'd19;
    for (int c = 0; c < 12; c++) begin
      tick();
      exp_v = sb.pop_front(); n_total++;
      if (obs() !== exp_v) $display("FAIL noise_hold_sb cyc=%0d got=%b exp=%b", c, obs(), exp_v);
      else n_pass++;
      if (alarm !== 1'b0 || zone !== 3'b000) bad = 1;
    end
    // Two isolated single-scan hits; a counter that failed to clear would fire on the second.
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 3 && m_scan != 1; k++) begin
        tick();
        exp_v = sb.pop_front(); n_total++;
        if (obs() !== exp_v) $display("FAIL noise_align_sb got=%b exp=%b", obs(), exp_v);
        else n_pass++;
      end
      pir_sensor_2 = 7'd25;
      tick();
      pir_sensor_2 = 7'd19;
      exp_v = sb.pop_front(); n_total++;
      if (obs() !== exp_v) $display("FAIL noise_pulse_sb pulse=%0d got=%b exp=%b", p, obs(), exp_v);
      else n_pass++;
      for (int c = 0; c < 4; c++) begin
        tick();
        exp_v = sb.pop_front(); n_total++;
        if (obs() !== exp_v) $display("FAIL noise_after_sb got=%b exp=%b", obs(), exp_v);
        else n_pass++;
        if (alarm !== 1'b0 || zone !== 3'b000) bad = 1;
      end
    end
    pir_sensor_2 = 7'd0;
    n_total++;
    if (bad || state !== 2'd2) $display("FAIL noise_no_alarm alarm=%b zone=%b state=%0d exp=0/000/2", alarm, zone, state);
    else n_pass++;
  endtask

  task automatic test_disarm_priority();
    int got = 0;
    pir_sensor_1 = 7'd40;
    for (int c = 1; c <= 12 && got == 0; c++) begin
      tick();
      exp_v = sb.pop_front(); n_total++;
      if (obs() !== exp_v) $display("FAIL prio_sb cyc=%0d got=%b exp=%b", c, obs(), exp_v);
      else n_pass++;
      if (alarm === 1'b1) got = c;
    end
    n_total++;
    if (got == 0) $display("FAIL prio_alarm_timeout alarm=%b exp=1", alarm);
    else n_pass++;
    turn = 1'b0; stop_alarm = 1'b1;
    tick();
    stop_alarm = 1'b0; pir_sensor_1 = 7'd0;
    exp_v = sb.pop_front(); n_total++;
    if (obs() !== exp_v) $display("FAIL prio_disarm_sb got=%b exp=%b", obs(), exp_v);
    else n_pass++;
    n_total++;
    if (state !== 2'd0 || alarm !== 1'b0 || armed !== 1'b0 || zone !== 3'b000)
      $display("FAIL prio_disarm state=%0d alarm=%b armed=%b zone=%b exp=0/0/0/000", state, alarm, armed, zone);
    else n_pass++;
  endtask

  task automatic test_reset_arming();
    turn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp_v = sb.pop_front(); n_total++;
      if (obs() !== exp_v) $display("FAIL rst_arming_sb cyc=%0d got=%b exp=%b", c, obs(), exp_v);
      else n_pass++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_v = sb.pop_front(); n_total++;
    if (state !== 2'd0 || obs() !== exp_v) $display("FAIL rst_mid_arming got=%b exp=%b", obs(), exp_v);
    else n_pass++;
    for (int e = 1; e <= 5; e++) begin
      tick();
      exp_v = sb.pop_front(); n_total++;
      if (obs() !== exp_v) $display("FAIL rearm_sb edge=%0d got=%b exp=%b", e, obs(), exp_v);
      else n_pass++;
      if (e == 4) begin
        n_total++;
        if (state !== 2'd1) $display("FAIL rearm_still_arming state=%0d exp=1", state);
        else n_pass++;
      end
      if (e == 5) begin
        n_total++;
        if (state !== 2'd2 || armed !== 1'b1) $display("FAIL rearm_done state=%0d armed=%b exp=2/1", state, armed);
        else n_pass++;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_arm();
    test_detect();
    test_stop();
    test_noise();
    test_disarm_priority();
    test_reset_arming();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
